vga_pixel_fetch: RTL

- Upstream pixel source for the VGA timing driver. Streams the visible frame out of a framebuffer memory in raster order, one 12-bit {R,G,B} pixel per visible pixel clock.
- Decouples variable memory read latency from fixed VGA timing with a small prefetch FIFO.
- The timing driver supplies FRAME_START and PIXEL_REQ and consumes PIXEL_RGB.

---
 rtl/vga_pixel_fetch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: streams the visible frame from framebuffer memory through a prefetch FIFO; define VGA_PIXEL_FETCH_UNDERFLOW_CNT_EN to add UNDERFLOW_COUNT
module vga_pixel_fetch #(
  parameter int H_VISIBLE_AREA = 800,
  parameter int V_VISIBLE_AREA = 600,
  parameter int ADDR_WIDTH     = 19,
  parameter int FIFO_DEPTH     = 16,
  parameter int PIXEL_WIDTH    = 12
) (
  input  logic                         VGA_CLK,
  input  logic                         VGA_RST,
  input  logic                         FRAME_START,
  input  logic                         PIXEL_REQ,
  output logic [PIXEL_WIDTH-1:0]       PIXEL_RGB,
  output logic [ADDR_WIDTH-1:0]        MEM_ADDR,
  output logic                         MEM_RD,
  input  logic                         MEM_WAIT,
  input  logic                         MEM_RDATA_VALID,
  input  logic [PIXEL_WIDTH-1:0]       MEM_RDATA,
  output logic                         UNDERFLOW,
`ifdef VGA_PIXEL_FETCH_UNDERFLOW_CNT_EN
  output logic [15:0]                  UNDERFLOW_COUNT,
`endif
  output logic [$clog2(FIFO_DEPTH):0]  FIFO_LEVEL
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_VISIBLE_AREA * V_VISIBLE_AREA - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LW-1:0]          r_lvl;
  logic [LW-1:0]          r_out;
  logic [LW-1:0]          r_disc;
  logic [LW-1:0]          w_out_nxt;
  logic [LW:0]            w_credit;
  logic [PW-1:0]          r_wp;
  logic [PW-1:0]          r_rp;
  logic [PIXEL_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                   w_acc;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_uf;

  assign FIFO_LEVEL = r_lvl;

  // Next state and read request; FIFO plus in-flight reads never exceed the FIFO depth
  always_comb begin
    w_credit    = {1'b0, r_lvl} + {1'b0, r_out};
    MEM_RD      = (r_state == FETCH) && (w_credit < (LW+1)'(FIFO_DEPTH));
    w_acc       = MEM_RD && !MEM_WAIT;
    w_state_nxt = r_state;
    if (FRAME_START)
      w_state_nxt = FETCH;
    else if ((r_state == FETCH) && w_acc && (MEM_ADDR == LAST_ADDR))
      w_state_nxt = DONE;
  end

  // FIFO handshake terms; a new frame overrides pushes and pops on its start cycle
  always_comb begin
    w_out_nxt = r_out + LW'(w_acc) - LW'(MEM_RDATA_VALID);
    w_push    = MEM_RDATA_VALID && (r_disc == '0) && !FRAME_START;
    w_pop     = PIXEL_REQ && (r_lvl != '0) && !FRAME_START;
    w_uf      = PIXEL_REQ && (r_lvl == '0) && !FRAME_START;
  end

  // FSM state register
  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Read address, in-flight count, and stale returns to drop after a frame restart
  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST) begin
      MEM_ADDR <= '0;
      r_out    <= '0;
      r_disc   <= '0;
    end else begin
      r_out <= w_out_nxt;
      if (FRAME_START) begin
        MEM_ADDR <= '0;
        r_disc   <= w_out_nxt;
      end else begin
        if (w_acc) MEM_ADDR <= MEM_ADDR + 1'b1;
        if (MEM_RDATA_VALID && (r_disc != '0)) r_disc <= r_disc - 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; frame start empties the FIFO
  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST || FRAME_START) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_lvl <= r_lvl + LW'(w_push) - LW'(w_pop);
    end
  end

  // FIFO storage
  always_ff @(posedge VGA_CLK) begin
    if (w_push) r_mem[r_wp] <= MEM_RDATA;
  end

  // Pixel output (black when blanking or starved) and sticky underflow flag
  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST) begin
      PIXEL_RGB <= '0;
      UNDERFLOW <= 1'b0;
    end else begin
      PIXEL_RGB <= w_pop ? r_mem[r_rp] : '0;
      UNDERFLOW <= FRAME_START ? 1'b0 : (UNDERFLOW || w_uf);
    end
  end

`ifdef VGA_PIXEL_FETCH_UNDERFLOW_CNT_EN
  // Saturating underflow event counter, survives frame restarts
  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST)                                UNDERFLOW_COUNT <= '0;
    else if (w_uf && (UNDERFLOW_COUNT != 16'hFFFF)) UNDERFLOW_COUNT <= UNDERFLOW_COUNT + 16'd1;
  end
`endif

endmodule
